wb_sdram_arbiter: RTL and testbench

- Round-robin Wishbone B3 arbiter sharing the single SDRAM controller slave port among NR_OF_WBM bridged masters, all in the SDRAM clock domain.
- Replaces the hard-wired master-1 connection in the multi-master bench and system top.
- Grant is cycle-locked: held for the whole cyc_i assertion, including bursts.
- Optional hold limit preempts at a transaction boundary when other masters are waiting.

---
 rtl/wb_sdram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone B3 arbiter in front of the single SDRAM controller port.
// Grant is cycle-locked, with optional hold-limit preemption at transfer ends.
module wb_sdram_arbiter #(
    parameter int NR_OF_WBM  = 2,
    parameter int HOLD_LIMIT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NR_OF_WBM*32-1:0] wbm_dat_i,
    input  logic [NR_OF_WBM*30-1:0] wbm_adr_i,
    input  logic [NR_OF_WBM*4-1:0]  wbm_sel_i,
    input  logic [NR_OF_WBM*3-1:0]  wbm_cti_i,
    input  logic [NR_OF_WBM*2-1:0]  wbm_bte_i,
    input  logic [NR_OF_WBM-1:0]    wbm_we_i,
    input  logic [NR_OF_WBM-1:0]    wbm_cyc_i,
    input  logic [NR_OF_WBM-1:0]    wbm_stb_i,
    output logic [31:0]             wbm_dat_o,
    output logic [NR_OF_WBM-1:0]    wbm_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [29:0]             wbs_adr_o,
    output logic [3:0]              wbs_sel_o,
    output logic [2:0]              wbs_cti_o,
    output logic [1:0]              wbs_bte_o,
    output logic                    wbs_we_o,
    output logic                    wbs_cyc_o,
    output logic                    wbs_stb_o,
    input  logic [31:0]             wbs_dat_i,
    input  logic                    wbs_ack_i,
    output logic [NR_OF_WBM-1:0]    grant_o
);

    localparam int IW = (NR_OF_WBM > 1) ? $clog2(NR_OF_WBM) : 1;
    localparam int HW = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);
    localparam logic [IW-1:0] LAST_RST = IW'(NR_OF_WBM - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e               state_q, state_d;
    logic [NR_OF_WBM-1:0] grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic [HW-1:0]        hold_q, hold_d;

    logic                 others;
    logic                 held_cyc;
    logic                 xfer_end;
    logic                 preempt;
    logic [IW:0]          pick_all;
    logic [IW:0]          pick_oth;

    // Returns {found, index}; search begins one past base and wraps.
    function automatic logic [IW:0] rr_pick(
        input logic [NR_OF_WBM-1:0] req,
        input logic [IW-1:0]        base
    );
        logic          found;
        logic [IW-1:0] idx;
        int            j;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NR_OF_WBM; i++) begin
            j = int'(base) + i;
            if (j >= NR_OF_WBM) j = j - NR_OF_WBM;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        wbs_dat_o = '0;
        wbs_adr_o = '0;
        wbs_sel_o = '0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        for (int k = 0; k < NR_OF_WBM; k++) begin
            if (grant_q[k]) begin
                wbs_dat_o = wbm_dat_i[k*32 +: 32];
                wbs_adr_o = wbm_adr_i[k*30 +: 30];
                wbs_sel_o = wbm_sel_i[k*4 +: 4];
                wbs_cti_o = wbm_cti_i[k*3 +: 3];
                wbs_bte_o = wbm_bte_i[k*2 +: 2];
                wbs_we_o  = wbm_we_i[k];
                wbs_cyc_o = wbm_cyc_i[k];
                wbs_stb_o = wbm_stb_i[k];
            end
        end
    end

    assign wbm_ack_o = {NR_OF_WBM{wbs_ack_i}} & grant_q;
    assign wbm_dat_o = wbs_dat_i;
    assign grant_o   = grant_q;

    assign others   = |(wbm_cyc_i & ~grant_q);
    assign held_cyc = |(wbm_cyc_i & grant_q);
    assign xfer_end = wbs_ack_i &&
                      (wbs_cti_o == 3'b000 || wbs_cti_o == 3'b111);
    assign preempt  = (HOLD_LIMIT > 0) && (hold_q == HOLD_MAX) &&
                      others && xfer_end;
    assign pick_all = rr_pick(wbm_cyc_i, last_q);
    // In BUSY last_q is the holder, so this skips the departing master.
    assign pick_oth = rr_pick(wbm_cyc_i & ~grant_q, last_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (pick_all[IW]) begin
                    state_d               = BUSY;
                    grant_d               = '0;
                    grant_d[pick_all[IW-1:0]] = 1'b1;
                    last_d                = pick_all[IW-1:0];
                    hold_d                = '0;
                end
            end
            BUSY: begin
                if (!held_cyc || preempt) begin
                    hold_d = '0;
                    if (pick_oth[IW]) begin
                        grant_d               = '0;
                        grant_d[pick_oth[IW-1:0]] = 1'b1;
                        last_d                = pick_oth[IW-1:0];
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (others && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench: a 2-master unlimited-hold instance and a 3-master
// instance with HOLD_LIMIT=4, driven from a cycle-by-cycle vector table.
module tb_wb_sdram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [2:0] cyc;
        logic [2:0] cti;
        logic       ack;
        logic [2:0] grant;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [2:0]  cti_v = '0;
    logic [31:0] sdat  = '0;
    logic [1:0]  c0 = '0;
    logic        a0 = 1'b0;
    logic [2:0]  c1 = '0;
    logic        a1 = 1'b0;

    logic [31:0] u0_mdat, u0_sdat;
    logic [1:0]  u0_mack, u0_grant;
    logic [29:0] u0_adr;
    logic [3:0]  u0_sel;
    logic [2:0]  u0_cti;
    logic [1:0]  u0_bte;
    logic        u0_we, u0_cyc, u0_stb;

    logic [31:0] u1_mdat, u1_sdat;
    logic [2:0]  u1_mack, u1_grant;
    logic [29:0] u1_adr;
    logic [3:0]  u1_sel;
    logic [2:0]  u1_cti;
    logic [1:0]  u1_bte;
    logic        u1_we, u1_cyc, u1_stb;

    wb_sdram_arbiter #(.NR_OF_WBM(2), .HOLD_LIMIT(0)) u0 (
        .clk(clk), .rst(rst),
        .wbm_dat_i({32'h2222_2222, 32'h1111_1111}),
        .wbm_adr_i({30'h200, 30'h100}),
        .wbm_sel_i({4'hc, 4'h3}),
        .wbm_cti_i({2{cti_v}}),
        .wbm_bte_i(4'b0),
        .wbm_we_i(2'b10),
        .wbm_cyc_i(c0), .wbm_stb_i(c0),
        .wbm_dat_o(u0_mdat), .wbm_ack_o(u0_mack),
        .wbs_dat_o(u0_sdat), .wbs_adr_o(u0_adr), .wbs_sel_o(u0_sel),
        .wbs_cti_o(u0_cti), .wbs_bte_o(u0_bte), .wbs_we_o(u0_we),
        .wbs_cyc_o(u0_cyc), .wbs_stb_o(u0_stb),
        .wbs_dat_i(sdat), .wbs_ack_i(a0), .grant_o(u0_grant)
    );

    wb_sdram_arbiter #(.NR_OF_WBM(3), .HOLD_LIMIT(4)) u1 (
        .clk(clk), .rst(rst),
        .wbm_dat_i({32'h3333_3333, 32'h2222_2222, 32'h1111_1111}),
        .wbm_adr_i({30'h300, 30'h200, 30'h100}),
        .wbm_sel_i({4'hf, 4'hc, 4'h3}),
        .wbm_cti_i({3{cti_v}}),
        .wbm_bte_i(6'b0),
        .wbm_we_i(3'b110),
        .wbm_cyc_i(c1), .wbm_stb_i(c1),
        .wbm_dat_o(u1_mdat), .wbm_ack_o(u1_mack),
        .wbs_dat_o(u1_sdat), .wbs_adr_o(u1_adr), .wbs_sel_o(u1_sel),
        .wbs_cti_o(u1_cti), .wbs_bte_o(u1_bte), .wbs_we_o(u1_we),
        .wbs_cyc_o(u1_cyc), .wbs_stb_o(u1_stb),
        .wbs_dat_i(sdat), .wbs_ack_i(a1), .grant_o(u1_grant)
    );

    task automatic add(input logic s, input logic [2:0] c,
                       input logic [2:0] t, input logic a,
                       input logic [2:0] g);
        vec_t v;
        v.sel = s; v.cyc = c; v.cti = t; v.ack = a; v.grant = g;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h, expected %0h",
                     nm, idx, act, exp);
        end
    endtask

    initial begin
        logic [2:0]  g, ag, aack;
        logic [29:0] eadr, aadr;
        logic [31:0] edat, adat, amdat;
        logic [2:0]  acti;
        logic        acyc, astb, awe;

        // 2-master: single read, idle return, then 8-beat burst lock
        add(0, 3'b000, 3'd0, 0, 3'b000);
        add(0, 3'b001, 3'd0, 0, 3'b000);
        add(0, 3'b001, 3'd0, 1, 3'b001);
        add(0, 3'b000, 3'd0, 0, 3'b001);
        add(0, 3'b000, 3'd0, 0, 3'b000);
        add(0, 3'b010, 3'd2, 0, 3'b000);
        for (int b = 0; b < 8; b++)
            add(0, 3'b011, (b == 7) ? 3'd7 : 3'd2, 1, 3'b010);
        add(0, 3'b001, 3'd0, 0, 3'b010);
        add(0, 3'b001, 3'd0, 1, 3'b001);
        add(0, 3'b000, 3'd0, 0, 3'b001);
        add(0, 3'b000, 3'd0, 0, 3'b000);
        // 3-master: simultaneous requests rotate 0,1,2,0 with no gap
        add(1, 3'b111, 3'd0, 0, 3'b000);
        add(1, 3'b111, 3'd0, 1, 3'b001);
        add(1, 3'b110, 3'd0, 0, 3'b001);
        add(1, 3'b111, 3'd0, 1, 3'b010);
        add(1, 3'b101, 3'd0, 0, 3'b010);
        add(1, 3'b101, 3'd0, 1, 3'b100);
        add(1, 3'b011, 3'd0, 0, 3'b100);
        add(1, 3'b011, 3'd0, 1, 3'b001);
        add(1, 3'b010, 3'd0, 0, 3'b001);
        add(1, 3'b010, 3'd0, 1, 3'b010);
        add(1, 3'b000, 3'd0, 0, 3'b010);
        add(1, 3'b000, 3'd0, 0, 3'b000);
        // hold-limit preemption on classic transfers
        add(1, 3'b001, 3'd0, 0, 3'b000);
        add(1, 3'b001, 3'd0, 1, 3'b001);
        add(1, 3'b011, 3'd0, 0, 3'b001);
        add(1, 3'b011, 3'd0, 1, 3'b001);
        add(1, 3'b011, 3'd0, 0, 3'b001);
        add(1, 3'b011, 3'd0, 1, 3'b001);
        add(1, 3'b011, 3'd0, 0, 3'b001);
        add(1, 3'b011, 3'd0, 1, 3'b001);
        add(1, 3'b011, 3'd0, 0, 3'b010);
        add(1, 3'b011, 3'd0, 1, 3'b010);
        add(1, 3'b001, 3'd0, 0, 3'b010);
        add(1, 3'b001, 3'd0, 1, 3'b001);
        add(1, 3'b000, 3'd0, 0, 3'b001);
        add(1, 3'b000, 3'd0, 0, 3'b000);
        // hold limit reached inside a burst: only the last beat yields
        add(1, 3'b001, 3'd2, 0, 3'b000);
        for (int b = 0; b < 6; b++)
            add(1, 3'b011, 3'd2, 1, 3'b001);
        add(1, 3'b011, 3'd7, 1, 3'b001);
        add(1, 3'b010, 3'd0, 0, 3'b010);
        add(1, 3'b000, 3'd0, 0, 3'b010);
        add(1, 3'b000, 3'd0, 0, 3'b000);

        repeat (3) @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            cti_v = tbl[i].cti;
            sdat  = 32'hd000_0000 + 32'(i);
            c0    = tbl[i].sel ? 2'b00 : tbl[i].cyc[1:0];
            a0    = tbl[i].sel ? 1'b0 : tbl[i].ack;
            c1    = tbl[i].sel ? tbl[i].cyc : 3'b000;
            a1    = tbl[i].sel ? tbl[i].ack : 1'b0;
            @(negedge clk);
            g = tbl[i].grant;
            if (tbl[i].sel) begin
                ag = u1_grant; aack = u1_mack; aadr = u1_adr;
                adat = u1_sdat; acti = u1_cti; acyc = u1_cyc;
                astb = u1_stb; awe = u1_we; amdat = u1_mdat;
            end else begin
                ag = {1'b0, u0_grant}; aack = {1'b0, u0_mack};
                aadr = u0_adr; adat = u0_sdat; acti = u0_cti;
                acyc = u0_cyc; astb = u0_stb; awe = u0_we;
                amdat = u0_mdat;
            end
            eadr = g[0] ? 30'h100 : g[1] ? 30'h200 : g[2] ? 30'h300 : 30'h0;
            edat = g[0] ? 32'h1111_1111 : g[1] ? 32'h2222_2222 :
                   g[2] ? 32'h3333_3333 : 32'h0;
            chk("grant", i, 32'(ag), 32'(g));
            chk("wbs_cyc", i, 32'(acyc), 32'(|(g & tbl[i].cyc)));
            chk("wbs_stb", i, 32'(astb), 32'(|(g & tbl[i].cyc)));
            chk("wbm_ack", i, 32'(aack), 32'(tbl[i].ack ? g : 3'b000));
            chk("wbs_adr", i, 32'(aadr), 32'(eadr));
            chk("wbs_dat", i, adat, edat);
            chk("wbs_we", i, 32'(awe), 32'(g[1] | g[2]));
            chk("wbs_cti", i, 32'(acti), 32'((|g) ? tbl[i].cti : 3'b000));
            chk("wbm_dat", i, amdat, 32'hd000_0000 + 32'(i));
        end

        // async reset during beat 2 of a 4-beat read on the 2-master port
        @(posedge clk);
        #1;
        c0 = 2'b01; cti_v = 3'b010; a0 = 1'b0;
        @(posedge clk);
        #1;
        a0 = 1'b1;
        @(negedge clk);
        chk("rst_pre_grant", 100, 32'(u0_grant), 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_grant", 101, 32'(u0_grant), 32'h0);
        chk("rst_cyc", 101, 32'(u0_cyc), 32'h0);
        chk("rst_stb", 101, 32'(u0_stb), 32'h0);
        chk("rst_ack", 101, 32'(u0_mack), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        c0 = 2'b11; cti_v = 3'b000; a0 = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 102, 32'(u0_grant), 32'h1);
        c0 = 2'b00;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
